vote_tally: RTL and testbench

//  Downstream consumer of the 3-input majority vote stage. Accepts one ballot

---
 rtl/vote_tally_pkg.sv | 11 +
 rtl/vote_majority.sv | 9 +
 rtl/vote_tally.sv | 119 +++++++++++
 tb/tb_vote_tally.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vote_tally_pkg.sv
// Shared definitions for the vote tally block: FSM state encodings and default sizing.
package vote_tally_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned MAX_ROUNDS_DEF = 200;
endpackage

// File: rtl/vote_majority.sv
// Pure 2-of-3 majority of one ballot triple.
module vote_majority (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic maj
);
  assign maj = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/vote_tally.sv
// Session-based tally of 2-of-3 majority ballots with pass/fail/total counts and verdict.
// Optional feature: define TALLY_UNANIMOUS_EN to add the uni_cnt output.
module vote_tally
  import vote_tally_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             close,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  output logic             in_ready,
  output logic             last_result,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic             busy,
  output logic             done,
  output logic             verdict
`ifdef TALLY_UNANIMOUS_EN
  ,
  output logic [CNT_W-1:0] uni_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             last_q, last_d;
  logic             maj, accept, last_round;
`ifdef TALLY_UNANIMOUS_EN
  logic [CNT_W-1:0] uni_q, uni_d;
`endif

  vote_majority u_maj (.a(in_a), .b(in_b), .c(in_c), .maj(maj));

  assign in_ready   = (state_q == S_COLLECT);
  assign accept     = in_valid & in_ready;
  // The accept that brings total up to MAX_ROUNDS closes the session at the same edge.
  assign last_round = accept && (total_q == CNT_W'(MAX_ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    total_d = total_q;
    last_d  = last_q;
`ifdef TALLY_UNANIMOUS_EN
    uni_d   = uni_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COLLECT;
          pass_d  = '0;
          fail_d  = '0;
          total_d = '0;
          last_d  = 1'b0;
`ifdef TALLY_UNANIMOUS_EN
          uni_d   = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (accept) begin
          total_d = total_q + 1'b1;
          last_d  = maj;
          if (maj) pass_d = pass_q + 1'b1;
          else     fail_d = fail_q + 1'b1;
`ifdef TALLY_UNANIMOUS_EN
          if ((in_a == in_b) && (in_b == in_c)) uni_d = uni_q + 1'b1;
`endif
        end
        if (close || last_round) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      fail_q  <= '0;
      total_q <= '0;
      last_q  <= 1'b0;
`ifdef TALLY_UNANIMOUS_EN
      uni_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      total_q <= total_d;
      last_q  <= last_d;
`ifdef TALLY_UNANIMOUS_EN
      uni_q   <= uni_d;
`endif
    end
  end

  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign total_cnt   = total_q;
  assign last_result = last_q;
  assign busy        = (state_q == S_COLLECT);
  assign done        = (state_q == S_DONE);
  assign verdict     = (state_q == S_DONE) && (pass_q > fail_q);
`ifdef TALLY_UNANIMOUS_EN
  assign uni_cnt     = uni_q;
`endif

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: a default instance and a MAX_ROUNDS=4 instance share stimulus
// and are both compared every cycle against a session-level reference model.
module tb_vote_tally;
  logic clk = 1'b0;
  logic reset, start, close, in_valid, in_a, in_b, in_c;

  logic [1:0]      in_ready_o, last_o, busy_o, done_o, verdict_o;
  logic [1:0][7:0] pass_o, fail_o, total_o;
`ifdef TALLY_UNANIMOUS_EN
  logic [1:0][7:0] uni_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // reference model state per instance: phase 0=idle 1=collecting 2=closed
  int max_r [2] = '{200, 4};
  int ph [2], m_pass [2], m_fail [2], m_total [2], m_uni [2];
  bit m_last [2];

  always #5 clk = ~clk;

  vote_tally dut (
    .clk(clk), .reset(reset), .start(start), .close(close), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_ready(in_ready_o[0]),
    .last_result(last_o[0]), .pass_cnt(pass_o[0]), .fail_cnt(fail_o[0]),
    .total_cnt(total_o[0]), .busy(busy_o[0]), .done(done_o[0]), .verdict(verdict_o[0])
`ifdef TALLY_UNANIMOUS_EN
    , .uni_cnt(uni_o[0])
`endif
  );

  vote_tally #(.CNT_W(8), .MAX_ROUNDS(4)) dut_small (
    .clk(clk), .reset(reset), .start(start), .close(close), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_ready(in_ready_o[1]),
    .last_result(last_o[1]), .pass_cnt(pass_o[1]), .fail_cnt(fail_o[1]),
    .total_cnt(total_o[1]), .busy(busy_o[1]), .done(done_o[1]), .verdict(verdict_o[1])
`ifdef TALLY_UNANIMOUS_EN
    , .uni_cnt(uni_o[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ph[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_total[i] = 0; m_uni[i] = 0; m_last[i] = 0;
      end else if (ph[i] == 1) begin
        if (in_valid) begin
          bit mj;
          mj = (int'(in_a) + int'(in_b) + int'(in_c)) >= 2;
          m_total[i]++;
          if (mj) m_pass[i]++; else m_fail[i]++;
          m_last[i] = mj;
          if (in_a == in_b && in_b == in_c) m_uni[i]++;
        end
        if (close || m_total[i] == max_r[i]) ph[i] = 2;
      end else if (start) begin
        ph[i] = 1; m_pass[i] = 0; m_fail[i] = 0; m_total[i] = 0; m_uni[i] = 0; m_last[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string s;
      s = (i == 0) ? "d0" : "d4";
      chk({s, "_in_ready"}, 32'(in_ready_o[i]), 32'(ph[i] == 1));
      chk({s, "_busy"},     32'(busy_o[i]),     32'(ph[i] == 1));
      chk({s, "_done"},     32'(done_o[i]),     32'(ph[i] == 2));
      chk({s, "_verdict"},  32'(verdict_o[i]),  32'(ph[i] == 2 && m_pass[i] > m_fail[i]));
      chk({s, "_last"},     32'(last_o[i]),     32'(m_last[i]));
      chk({s, "_pass"},     32'(pass_o[i]),     32'(m_pass[i]));
      chk({s, "_fail"},     32'(fail_o[i]),     32'(m_fail[i]));
      chk({s, "_total"},    32'(total_o[i]),    32'(m_total[i]));
`ifdef TALLY_UNANIMOUS_EN
      chk({s, "_uni"},      32'(uni_o[i]),      32'(m_uni[i]));
`endif
    end
  endtask

  // apply inputs, advance one clock, compare on the falling edge
  task automatic cyc(input bit r, st, cl, v, a, b, c);
    reset = r; start = st; close = cl; in_valid = v; in_a = a; in_b = b; in_c = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic ballot(input bit a, b, c);
    cyc(0, 0, 0, 1, a, b, c);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; start = 0; close = 0; in_valid = 0; in_a = 0; in_b = 0; in_c = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // basic session
    cyc(0, 1, 0, 0, 0, 0, 0);
    ballot(1, 1, 0); ballot(0, 0, 1); ballot(1, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("t1_pass", 32'(pass_o[0]), 2);
    chk("t1_fail", 32'(fail_o[0]), 1);
    chk("t1_total", 32'(total_o[0]), 3);
    chk("t1_last", 32'(last_o[0]), 1);
    chk("t1_done", 32'(done_o[0]), 1);
    chk("t1_verdict", 32'(verdict_o[0]), 1);

    // ballots offered while closed or idle are dropped
    ballot(1, 1, 1); ballot(1, 1, 1);
    chk("t2_total_done", 32'(total_o[0]), 3);
    cyc(1, 0, 0, 0, 0, 0, 0);
    ballot(1, 1, 1); ballot(1, 1, 1);
    chk("t2_total_idle", 32'(total_o[0]), 0);
    chk("t2_ready_idle", 32'(in_ready_o[0]), 0);

    // auto-close at MAX_ROUNDS on the small instance
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) ballot(1, 1, 1);
    chk("t3_total4", 32'(total_o[1]), 4);
    chk("t3_done4", 32'(done_o[1]), 1);
    chk("t3_total200", 32'(total_o[0]), 6);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // close coincident with an accepted ballot
    cyc(0, 1, 0, 0, 0, 0, 0);
    ballot(1, 1, 1); ballot(1, 1, 1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("t4_fail", 32'(fail_o[0]), 1);
    chk("t4_total", 32'(total_o[0]), 3);
    chk("t4_verdict", 32'(verdict_o[0]), 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("t4_restart_total", 32'(total_o[0]), 0);
    chk("t4_restart_busy", 32'(busy_o[0]), 1);
    // start together with close in COLLECT: close wins
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("t4_close_wins", 32'(done_o[0]), 1);

    // reset mid-session, then a tied session
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) ballot(1, 0, 1);
    chk("t5_total5", 32'(total_o[0]), 5);
    cyc(1, 0, 0, 1, 1, 1, 1);
    chk("t5_rst_total", 32'(total_o[0]), 0);
    chk("t5_rst_busy", 32'(busy_o[0]), 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    ballot(1, 1, 0); ballot(0, 1, 1); ballot(0, 0, 0); ballot(1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("t5_tie_verdict", 32'(verdict_o[0]), 0);
    chk("t5_tie_done", 32'(done_o[0]), 1);

`ifdef TALLY_UNANIMOUS_EN
    cyc(0, 1, 0, 0, 0, 0, 0);
    ballot(1, 1, 1); ballot(0, 0, 0); ballot(1, 1, 0);
    chk("t6_uni", 32'(uni_o[0]), 2);
    cyc(0, 0, 1, 0, 0, 0, 0);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
